// File: rtl/gray_counter_if.sv
// Control and count bus for gray_counter; the master drives controls, the slave returns the count.
interface gray_counter_if #(
    parameter int unsigned DataWidth = 4
);
    logic                 clear_i;
    logic                 load_i;
    logic [DataWidth-1:0] load_data_i;
    logic                 en_i;
    logic                 dir_i;
    logic [DataWidth-1:0] gray_o;
    logic [DataWidth-1:0] bin_o;
    logic                 wrap_o;

    modport master (
        output clear_i,
        output load_i,
        output load_data_i,
        output en_i,
        output dir_i,
        input  gray_o,
        input  bin_o,
        input  wrap_o
    );

    modport slave (
        input  clear_i,
        input  load_i,
        input  load_data_i,
        input  en_i,
        input  dir_i,
        output gray_o,
        output bin_o,
        output wrap_o
    );
endinterface

// File: rtl/gray_counter.sv
// Binary counter with a separately registered Gray-code output and a registered wrap pulse.
// Define GRAY_COUNTER_DOWN_EN to honour dir_i (up/down counting); otherwise the counter counts up only.
module gray_counter #(
    parameter int unsigned DataWidth = 4
) (
    input logic           clk_i,
    input logic           arst_ni,
    gray_counter_if.slave bus
);

    logic [DataWidth-1:0] bin_q, bin_d;
    logic [DataWidth-1:0] gray_q, gray_d;
    logic                 wrap_q, wrap_d;
    logic [DataWidth:0]   inc_w;

    // The extra top bit carries out of the increment and feeds only the wrap pulse.
    assign inc_w = {1'b0, bin_q} + {{DataWidth{1'b0}}, 1'b1};

`ifdef GRAY_COUNTER_DOWN_EN
    logic [DataWidth:0] dec_w;
    assign dec_w = {1'b0, bin_q} - {{DataWidth{1'b0}}, 1'b1};
`else
    logic unused_dir;
    assign unused_dir = bus.dir_i;
`endif

    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (bus.clear_i) begin
            bin_d = '0;
        end else if (bus.load_i) begin
            bin_d = bus.load_data_i;
        end else if (bus.en_i) begin
`ifdef GRAY_COUNTER_DOWN_EN
            if (bus.dir_i) begin
                bin_d  = dec_w[DataWidth-1:0];
                wrap_d = dec_w[DataWidth];
            end else begin
                bin_d  = inc_w[DataWidth-1:0];
                wrap_d = inc_w[DataWidth];
            end
`else
            bin_d  = inc_w[DataWidth-1:0];
            wrap_d = inc_w[DataWidth];
`endif
        end
        // Gray is encoded from the next binary value so gray_q is a plain register output.
        gray_d = bin_d ^ (bin_d >> 1);
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            bin_q  <= '0;
            gray_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    assign bus.bin_o  = bin_q;
    assign bus.gray_o = gray_q;
    assign bus.wrap_o = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter (DataWidth=4) against an arithmetic reference model.
module tb_gray_counter;

    localparam int W   = 4;
    localparam int MOD = 16;
`ifdef GRAY_COUNTER_DOWN_EN
    localparam bit DownEn = 1'b1;
`else
    localparam bit DownEn = 1'b0;
`endif

    logic clk;
    logic arst_n;
    int   total;
    int   bad;
    int   m_bin;
    bit   m_wrap;
    logic [W-1:0] seq_exp [0:16];
    logic [W-1:0] prev_gray;

    gray_counter_if #(.DataWidth(W)) bus ();

    gray_counter #(.DataWidth(W)) dut (
        .clk_i  (clk),
        .arst_ni(arst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] gray_of(input int b);
        logic [W-1:0] v;
        v = W'(b);
        return v ^ (v >> 1);
    endfunction

    // Reference Gray-to-binary decoder: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [W-1:0] gray_to_bin(input logic [W-1:0] g);
        logic [W-1:0] r;
        r = '0;
        for (int i = W - 1; i >= 0; i--) begin
            r[i] = ^(g >> i);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        check({tag, ".bin"}, bus.bin_o, W'(m_bin));
        check({tag, ".gray"}, bus.gray_o, gray_of(m_bin));
        check({tag, ".wrap"}, W'(bus.wrap_o), W'(m_wrap));
    endtask

    // Drive one cycle of controls, wait for the edge, then advance the reference model.
    task automatic applyStimulus(input bit clr, input bit ld, input int data, input bit en, input bit dir);
        bus.clear_i     = clr;
        bus.load_i      = ld;
        bus.load_data_i = W'(data);
        bus.en_i        = en;
        bus.dir_i       = dir;
        @(posedge clk);
        #1;
        m_wrap = 1'b0;
        if (clr) begin
            m_bin = 0;
        end else if (ld) begin
            m_bin = data % MOD;
        end else if (en) begin
            if (DownEn && dir) begin
                m_wrap = (m_bin == 0);
                m_bin  = (m_bin + MOD - 1) % MOD;
            end else begin
                m_wrap = (m_bin == MOD - 1);
                m_bin  = (m_bin + 1) % MOD;
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        m_bin = 0;
        m_wrap = 1'b0;
        seq_exp = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                    4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

        // Reset held while controls try to count and load.
        arst_n = 1'b0;
        bus.clear_i = 1'b0;
        bus.load_i = 1'b1;
        bus.load_data_i = 4'h5;
        bus.en_i = 1'b1;
        bus.dir_i = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("reset");

        // Release between edges, then 16 up steps with the exact Gray sequence.
        arst_n = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            prev_gray = bus.gray_o;
            applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b0);
            checkOutput("up");
            check("up.seq", bus.gray_o, seq_exp[i]);
            check("up.hamming", W'($countones(prev_gray ^ bus.gray_o)), 4'd1);
        end
        applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b0);
        checkOutput("hold");

        // Load beats enable, then a normal step.
        applyStimulus(1'b0, 1'b1, 'hA, 1'b1, 1'b0);
        checkOutput("load_a");
        check("load_a.gray_const", bus.gray_o, 4'hF);
        applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b0);
        checkOutput("load_a_step");
        check("load_a_step.gray_const", bus.gray_o, 4'hE);

        // Clear beats load and enable.
        applyStimulus(1'b0, 1'b1, 7, 1'b0, 1'b0);
        checkOutput("load_7");
        applyStimulus(1'b1, 1'b1, 3, 1'b1, 1'b0);
        checkOutput("clear_prio");

        // Down request from zero; outcome depends on the build.
        applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b1);
        checkOutput("down_from_zero");
        if (DownEn) check("down_from_zero.gray_const", bus.gray_o, 4'h8);
        else        check("down_from_zero.gray_const", bus.gray_o, 4'h1);
        applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b1);
        checkOutput("wrap_clears");

        // Random controls with mostly-enabled counting.
        for (int i = 0; i < 48; i++) begin
            bit clr, ld, en, dir;
            int data;
            clr  = ($urandom_range(0, 15) == 0);
            ld   = ($urandom_range(0, 9) == 0);
            en   = ($urandom_range(0, 3) != 0);
            dir  = $urandom_range(0, 1) != 0;
            data = $urandom_range(0, MOD - 1);
            prev_gray = bus.gray_o;
            applyStimulus(clr, ld, data, en, dir);
            checkOutput("rand");
            check("rand.decode", gray_to_bin(bus.gray_o), bus.bin_o);
            if (!clr && !ld && en)
                check("rand.hamming", W'($countones(prev_gray ^ bus.gray_o)), 4'd1);
        end

        // Reset mid-cycle discards a pending wrap pulse.
        applyStimulus(1'b0, 1'b1, 15, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b0);
        checkOutput("pre_reset_wrap");
        #2;
        arst_n = 1'b0;
        #1;
        m_bin = 0;
        m_wrap = 1'b0;
        checkOutput("reset_kills_wrap");
        @(negedge clk);
        arst_n = 1'b1;

        // Count to 9, reset between edges, then first step after release.
        applyStimulus(1'b0, 1'b1, 8, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b0);
        checkOutput("count_to_9");
        #2;
        arst_n = 1'b0;
        #1;
        m_bin = 0;
        m_wrap = 1'b0;
        checkOutput("async_reset");
        @(negedge clk);
        arst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b0);
        checkOutput("first_step");
        check("first_step.bin_const", bus.bin_o, 4'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gray_counter.md
GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 Parameter DataWidth, default 4, counter width in bits; legal range 2..32.
REQ-002 clk_i  input  1  clock; all state updates on rising edge.
REQ-003 arst_ni  input  1  asynchronous active-low reset.
REQ-004 clear_i  input  1  synchronous clear to zero.
REQ-005 load_i  input  1  synchronous load of load_data_i.
REQ-006 load_data_i  input  DataWidth  load value, binary-coded.
REQ-007 en_i  input  1  count enable, one step per enabled cycle.
REQ-008 dir_i  input  1  count direction: 0 = up, 1 = down; ignored unless GRAY_COUNTER_DOWN_EN is defined.
REQ-009 gray_o  output  DataWidth  registered Gray-coded count.
REQ-010 bin_o  output  DataWidth  registered binary count, always the binary equivalent of gray_o.
REQ-011 wrap_o  output  1  registered one-cycle pulse on counter wrap-around.

Function
REQ-012 The block SHALL hold an internal binary count register and SHALL drive gray_o from a dedicated register loaded with next_bin ^ (next_bin >> 1), so gray_o is never combinationally decoded and is glitch-free.
REQ-013 Per-cycle priority SHALL be: clear_i > load_i > en_i > hold.
REQ-014 clear_i=1: bin_o and gray_o SHALL become 0 next cycle; wrap_o SHALL be 0.
REQ-015 load_i=1 (clear_i=0): bin_o SHALL become load_data_i and gray_o its Gray encoding next cycle; wrap_o SHALL be 0.
REQ-016 en_i=1, up: bin_o SHALL increment by 1 modulo 2**DataWidth.
REQ-017 en_i=1, down: bin_o SHALL decrement by 1 modulo 2**DataWidth.
REQ-018 Latency from any control input to the outputs SHALL be exactly one clock cycle.
REQ-019 Consecutive gray_o values produced by counting SHALL differ in exactly one bit, including across wrap-around.
REQ-020 wrap_o SHALL be 1 for exactly the cycle after an up step from all-ones to zero, or a down step from zero to all-ones; 0 otherwise.
REQ-021 en_i=0 with no clear or load SHALL hold all outputs; wrap_o SHALL return to 0.
REQ-022 Simultaneous load_i and en_i SHALL load without stepping; simultaneous clear_i and load_i SHALL clear.
REQ-023 Arithmetic SHALL be DataWidth bits wide with the carry/borrow discarded; the carry/borrow SHALL be used only to generate wrap_o.

Reset
REQ-024 On arst_ni low, bin_o, gray_o and wrap_o SHALL go to 0 immediately, independent of clk_i.
REQ-025 During reset all inputs SHALL be ignored; the first count step SHALL occur on the first rising edge after arst_ni deasserts with en_i=1.
REQ-026 Reset asserted mid-count SHALL discard the count; no pending wrap_o pulse SHALL survive reset.

Configuration
REQ-027 Macro GRAY_COUNTER_DOWN_EN defined: dir_i SHALL be honoured, enabling up/down counting per REQ-016/017/020.
REQ-028 Macro GRAY_COUNTER_DOWN_EN undefined: the counter SHALL count up only, dir_i SHALL be unused, and no decrement logic SHALL be synthesised.

Verification (DataWidth=4)
REQ-029 Reset, then en_i=1 for 16 cycles up -> gray_o sequence 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0; wrap_o pulses once, in the cycle gray_o returns to 0.
REQ-030 Feed gray_o into a gray_to_bin instance for 2**DataWidth random enabled cycles -> its output equals bin_o every cycle; adjacent gray_o values have Hamming distance 1.
REQ-031 load_i=1, load_data_i=4'hA, en_i=1 -> next cycle bin_o=A, gray_o=F, wrap_o=0; one further enabled cycle -> bin_o=B, gray_o=E.
REQ-032 clear_i=1, load_i=1, en_i=1 with bin_o=7 -> next cycle bin_o=0, gray_o=0, wrap_o=0.
REQ-033 With GRAY_COUNTER_DOWN_EN: bin_o=0, dir_i=1, en_i=1 -> bin_o=F, gray_o=8, wrap_o=1 for one cycle; without the macro, the same stimulus -> bin_o=1, gray_o=1, wrap_o=0.
REQ-034 Count to bin_o=9, assert arst_ni low between clock edges -> all outputs 0 before the next edge; release with en_i=1 -> bin_o=1 after the first edge.
